ysyx_22050710_trap_seq: RTL and testbench
=========================================

YSYX_22050710_TRAP_SEQ -- requirements
Module: ysyx_22050710_trap_seq

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, CSR address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, CSR data width.
REQ-003 SHALL have port i_clk, input, 1, the single clock; all state updates on rising edge.
REQ-004 SHALL have port i_rst, input, 1, reset, asynchronous, active-high.
REQ-005 SHALL have port i_valid, input, 1, trap or mret request from the pipeline.
REQ-006 SHALL have port i_mret, input, 1, request type: 1=mret, 0=exception.
REQ-007 SHALL have port i_cause, input, 4, exception code; zero-extended into mcause.
REQ-008 SHALL have port i_epc, input, 64, pc of the trapping instruction.
REQ-009 SHALL have port o_ready, output, 1, sequencer idle; request accepted when i_valid && o_ready.
REQ-010 SHALL have port o_csr_raddr, output, ADDR_WIDTH, CSR read address.
REQ-011 SHALL have port o_csr_ren, output, 1, CSR read enable.
REQ-012 SHALL have port i_csr_rdata, input, DATA_WIDTH, CSR read data, combinational, same cycle as o_csr_ren.
REQ-013 SHALL have port o_csr_waddr, output, ADDR_WIDTH, CSR write address.
REQ-014 SHALL have port o_csr_wdata, output, DATA_WIDTH, CSR write data (plain write, no set/clear).
REQ-015 SHALL have port o_csr_wen, output, 1, CSR write enable, committed by the CSR file at next edge.
REQ-016 SHALL have port o_nextpc, output, 64, redirect target.
REQ-017 SHALL have port o_redirect, output, 1, one-cycle pc-redirect strobe.

Function
REQ-018 States SHALL be IDLE, W_EPC, W_CAUSE, U_STAT, R_VEC, M_STAT, R_EPC; o_ready=1 only in IDLE.
REQ-019 On acceptance SHALL latch i_epc and i_cause into internal registers; inputs ignored while o_ready=0.
REQ-020 Exception path SHALL be IDLE->W_EPC->W_CAUSE->U_STAT->R_VEC->IDLE, one cycle per state.
REQ-021 W_EPC SHALL drive wen=1, waddr=0x341, wdata=latched epc.
REQ-022 W_CAUSE SHALL drive wen=1, waddr=0x342, wdata={60'b0,latched cause}.
REQ-023 U_STAT SHALL read 0x300 and write 0x300 in the same cycle with MPIE(bit7)=old MIE(bit3), MIE=0, MPP(bits12:11)=2'b11, all other bits unchanged.
REQ-024 R_VEC SHALL read 0x305 and drive o_nextpc={rdata[63:2],2'b00}, o_redirect=1.
REQ-025 Mret path SHALL be IDLE->M_STAT->R_EPC->IDLE.
REQ-026 M_STAT SHALL read/write 0x300 with MIE=old MPIE, MPIE=1, MPP=2'b11, other bits unchanged.
REQ-027 R_EPC SHALL read 0x341 and drive o_nextpc=rdata, o_redirect=1.
REQ-028 Latency: redirect SHALL occur in the 4th cycle after the acceptance edge for exceptions, the 2nd for mret.
REQ-029 i_mret SHALL be sampled only at acceptance; any i_valid while busy SHALL be dropped, not queued.
REQ-030 Outside the states named above, o_csr_ren, o_csr_wen, o_redirect SHALL be 0 and addresses/data/o_nextpc 0.
REQ-031 A request accepted on the cycle following a redirect SHALL be processed normally (back-to-back supported).

Reset
REQ-032 On i_rst assertion, asynchronously: state=IDLE, latched epc/cause=0, all outputs 0 except o_ready=1.
REQ-033 Reset mid-sequence SHALL abandon it with no further CSR write or redirect; already-committed writes are not undone.

Structure
REQ-034 CSR addresses (0x300, 0x305, 0x341, 0x342), mstatus bit positions (MIE=3, MPIE=7, MPP=12:11) and the state encoding SHALL live in shared package ysyx_22050710_csr_pkg.
REQ-035 No sub-module; the mstatus update SHALL be a package function shared with the CSR file.

Verification
REQ-036 Exception i_cause=11, i_epc=0x80000010, mstatus=0xA00001808, mtvec=0x80000101 -> mepc=0x80000010, mcause=11, mstatus=0xA00001880, o_nextpc=0x80000100 pulsed 4 cycles after acceptance.
REQ-037 mret with mstatus=0xA00001880, mepc=0x80000014 -> mstatus=0xA00001888, o_nextpc=0x80000014, redirect 2 cycles after acceptance.
REQ-038 i_valid held high during an exception sequence with different epc -> only one sequence, original epc written, o_ready low 4 cycles.
REQ-039 i_rst pulsed during W_CAUSE -> no further wen/redirect, o_ready=1 immediately, mepc retains written value.
REQ-040 Exception then mret issued on the cycle after redirect -> both sequences complete, final pc equals original mepc.

Source files
------------

// File: rtl/ysyx_22050710_csr_pkg.sv
// Machine-mode CSR map, mstatus field positions, trap-sequencer state encoding
// and the mstatus update rules shared by the trap sequencer and the CSR file.
package ysyx_22050710_csr_pkg;

  localparam int XLEN = 64;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam logic [1:0] PRV_M = 2'b11;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_W_EPC   = 3'd1;
  localparam logic [2:0] ST_W_CAUSE = 3'd2;
  localparam logic [2:0] ST_U_STAT  = 3'd3;
  localparam logic [2:0] ST_R_VEC   = 3'd4;
  localparam logic [2:0] ST_M_STAT  = 3'd5;
  localparam logic [2:0] ST_R_EPC   = 3'd6;

  // Trap entry: stash MIE into MPIE, mask interrupts, record machine mode.
  function automatic logic [XLEN-1:0] mstatus_trap(input logic [XLEN-1:0] old_s);
    logic [XLEN-1:0] new_s;
    new_s                                = old_s;
    new_s[MSTATUS_MPIE]                  = old_s[MSTATUS_MIE];
    new_s[MSTATUS_MIE]                   = 1'b0;
    new_s[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRV_M;
    return new_s;
  endfunction

  // Trap return: restore MIE from MPIE and re-arm MPIE.
  function automatic logic [XLEN-1:0] mstatus_mret(input logic [XLEN-1:0] old_s);
    logic [XLEN-1:0] new_s;
    new_s                                = old_s;
    new_s[MSTATUS_MIE]                   = old_s[MSTATUS_MPIE];
    new_s[MSTATUS_MPIE]                  = 1'b1;
    new_s[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRV_M;
    return new_s;
  endfunction

endpackage

// File: rtl/ysyx_22050710_trap_seq.sv
// Trap / mret sequencer: walks the machine CSRs one access per cycle and
// issues a single-cycle pc redirect at the end of each sequence.
module ysyx_22050710_trap_seq
  import ysyx_22050710_csr_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  logic                  i_mret,
  input  logic [3:0]            i_cause,
  input  logic [63:0]           i_epc,
  output logic                  o_ready,
  output logic [ADDR_WIDTH-1:0] o_csr_raddr,
  output logic                  o_csr_ren,
  input  logic [DATA_WIDTH-1:0] i_csr_rdata,
  output logic [ADDR_WIDTH-1:0] o_csr_waddr,
  output logic [DATA_WIDTH-1:0] o_csr_wdata,
  output logic                  o_csr_wen,
  output logic [63:0]           o_nextpc,
  output logic                  o_redirect
);

  logic [2:0]      state_r;
  logic [2:0]      state_nxt_s;
  logic [63:0]     epc_r;
  logic [3:0]      cause_r;
  logic            accept_s;
  logic [XLEN-1:0] rdata_s;

  assign accept_s = (state_r == ST_IDLE) && i_valid;
  assign rdata_s  = XLEN'(i_csr_rdata);

  // Next-state selection; the request type is only looked at on acceptance.
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (i_valid) begin
          state_nxt_s = i_mret ? ST_M_STAT : ST_W_EPC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_W_EPC:   state_nxt_s = ST_W_CAUSE;
      ST_W_CAUSE: state_nxt_s = ST_U_STAT;
      ST_U_STAT:  state_nxt_s = ST_R_VEC;
      ST_R_VEC:   state_nxt_s = ST_IDLE;
      ST_M_STAT:  state_nxt_s = ST_R_EPC;
      ST_R_EPC:   state_nxt_s = ST_IDLE;
      default:    state_nxt_s = ST_IDLE;
    endcase
  end

  // State register and request capture.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
      epc_r   <= 64'd0;
      cause_r <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        epc_r   <= i_epc;
        cause_r <= i_cause;
      end else begin
        epc_r   <= epc_r;
        cause_r <= cause_r;
      end
    end
  end

  // CSR port and redirect decode; mstatus updates and redirect targets use
  // the same-cycle read data.
  always_comb begin
    o_ready     = (state_r == ST_IDLE);
    o_csr_raddr = {ADDR_WIDTH{1'b0}};
    o_csr_ren   = 1'b0;
    o_csr_waddr = {ADDR_WIDTH{1'b0}};
    o_csr_wdata = {DATA_WIDTH{1'b0}};
    o_csr_wen   = 1'b0;
    o_nextpc    = 64'd0;
    o_redirect  = 1'b0;
    case (state_r)
      ST_W_EPC: begin
        o_csr_wen   = 1'b1;
        o_csr_waddr = ADDR_WIDTH'(CSR_MEPC);
        o_csr_wdata = DATA_WIDTH'(epc_r);
      end
      ST_W_CAUSE: begin
        o_csr_wen   = 1'b1;
        o_csr_waddr = ADDR_WIDTH'(CSR_MCAUSE);
        o_csr_wdata = DATA_WIDTH'(cause_r);
      end
      ST_U_STAT: begin
        o_csr_ren   = 1'b1;
        o_csr_raddr = ADDR_WIDTH'(CSR_MSTATUS);
        o_csr_wen   = 1'b1;
        o_csr_waddr = ADDR_WIDTH'(CSR_MSTATUS);
        o_csr_wdata = DATA_WIDTH'(mstatus_trap(rdata_s));
      end
      ST_R_VEC: begin
        o_csr_ren   = 1'b1;
        o_csr_raddr = ADDR_WIDTH'(CSR_MTVEC);
        o_nextpc    = {rdata_s[63:2], 2'b00};
        o_redirect  = 1'b1;
      end
      ST_M_STAT: begin
        o_csr_ren   = 1'b1;
        o_csr_raddr = ADDR_WIDTH'(CSR_MSTATUS);
        o_csr_wen   = 1'b1;
        o_csr_waddr = ADDR_WIDTH'(CSR_MSTATUS);
        o_csr_wdata = DATA_WIDTH'(mstatus_mret(rdata_s));
      end
      ST_R_EPC: begin
        o_csr_ren   = 1'b1;
        o_csr_raddr = ADDR_WIDTH'(CSR_MEPC);
        o_nextpc    = rdata_s;
        o_redirect  = 1'b1;
      end
      default: begin
        o_redirect = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ysyx_22050710_trap_seq.sv
// Directed bench for the trap/mret sequencer with a small behavioural CSR file.
module tb_ysyx_22050710_trap_seq;

  logic        i_clk;
  logic        i_rst;
  logic        i_valid;
  logic        i_mret;
  logic [3:0]  i_cause;
  logic [63:0] i_epc;
  logic        o_ready;
  logic [11:0] o_csr_raddr;
  logic        o_csr_ren;
  logic [63:0] i_csr_rdata;
  logic [11:0] o_csr_waddr;
  logic [63:0] o_csr_wdata;
  logic        o_csr_wen;
  logic [63:0] o_nextpc;
  logic        o_redirect;

  logic [63:0] mstatus_m, mtvec_m, mepc_m, mcause_m;
  logic        poke_en;
  logic [11:0] poke_addr;
  logic [63:0] poke_data;

  int vec_cnt;
  int err_cnt;

  ysyx_22050710_trap_seq #(.ADDR_WIDTH(12), .DATA_WIDTH(64)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_valid     (i_valid),
    .i_mret      (i_mret),
    .i_cause     (i_cause),
    .i_epc       (i_epc),
    .o_ready     (o_ready),
    .o_csr_raddr (o_csr_raddr),
    .o_csr_ren   (o_csr_ren),
    .i_csr_rdata (i_csr_rdata),
    .o_csr_waddr (o_csr_waddr),
    .o_csr_wdata (o_csr_wdata),
    .o_csr_wen   (o_csr_wen),
    .o_nextpc    (o_nextpc),
    .o_redirect  (o_redirect)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Combinational CSR read port.
  always_comb begin
    i_csr_rdata = 64'd0;
    if (o_csr_ren) begin
      case (o_csr_raddr)
        12'h300: i_csr_rdata = mstatus_m;
        12'h305: i_csr_rdata = mtvec_m;
        12'h341: i_csr_rdata = mepc_m;
        12'h342: i_csr_rdata = mcause_m;
        default: i_csr_rdata = 64'd0;
      endcase
    end
  end

  // CSR file writes commit at the edge; the bench can preload registers.
  always @(posedge i_clk) begin
    if (o_csr_wen) begin
      case (o_csr_waddr)
        12'h300: mstatus_m <= o_csr_wdata;
        12'h305: mtvec_m   <= o_csr_wdata;
        12'h341: mepc_m    <= o_csr_wdata;
        12'h342: mcause_m  <= o_csr_wdata;
        default: ;
      endcase
    end else if (poke_en) begin
      case (poke_addr)
        12'h300: mstatus_m <= poke_data;
        12'h305: mtvec_m   <= poke_data;
        12'h341: mepc_m    <= poke_data;
        12'h342: mcause_m  <= poke_data;
        default: ;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%h, expected 0x%h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic poke(input logic [11:0] a, input logic [63:0] d);
    poke_en   = 1'b1;
    poke_addr = a;
    poke_data = d;
    tick();
    poke_en   = 1'b0;
  endtask

  task automatic request(input logic mret, input logic [3:0] cause, input logic [63:0] epc);
    i_valid = 1'b1;
    i_mret  = mret;
    i_cause = cause;
    i_epc   = epc;
  endtask

  initial begin
    vec_cnt   = 0;
    err_cnt   = 0;
    i_rst     = 1'b1;
    i_valid   = 1'b0;
    i_mret    = 1'b0;
    i_cause   = 4'd0;
    i_epc     = 64'd0;
    poke_en   = 1'b0;
    poke_addr = 12'd0;
    poke_data = 64'd0;
    #2;
    chk("rst_ready",    64'(o_ready),     64'd1);
    chk("rst_wen",      64'(o_csr_wen),   64'd0);
    chk("rst_ren",      64'(o_csr_ren),   64'd0);
    chk("rst_redirect", 64'(o_redirect),  64'd0);
    chk("rst_nextpc",   o_nextpc,         64'd0);
    chk("rst_waddr",    64'(o_csr_waddr), 64'd0);
    poke(12'h300, 64'hA_0000_1808);
    poke(12'h305, 64'h8000_0101);
    i_rst = 1'b0;
    tick();

    // Exception: cause 11 at 0x80000010.
    request(1'b0, 4'd11, 64'h8000_0010);
    tick();
    i_valid = 1'b0;
    chk("exc_c1_ready", 64'(o_ready),     64'd0);
    chk("exc_c1_wen",   64'(o_csr_wen),   64'd1);
    chk("exc_c1_waddr", 64'(o_csr_waddr), 64'h341);
    chk("exc_c1_wdata", o_csr_wdata,      64'h8000_0010);
    tick();
    chk("exc_c2_waddr", 64'(o_csr_waddr), 64'h342);
    chk("exc_c2_wdata", o_csr_wdata,      64'd11);
    tick();
    chk("exc_c3_raddr", 64'(o_csr_raddr), 64'h300);
    chk("exc_c3_waddr", 64'(o_csr_waddr), 64'h300);
    chk("exc_c3_wdata", o_csr_wdata,      64'hA_0000_1880);
    chk("exc_c3_redir", 64'(o_redirect),  64'd0);
    tick();
    chk("exc_c4_redir", 64'(o_redirect),  64'd1);
    chk("exc_c4_pc",    o_nextpc,         64'h8000_0100);
    chk("exc_c4_wen",   64'(o_csr_wen),   64'd0);
    tick();
    chk("exc_idle_redir", 64'(o_redirect), 64'd0);
    chk("exc_idle_ready", 64'(o_ready),    64'd1);
    chk("exc_mepc",    mepc_m,    64'h8000_0010);
    chk("exc_mcause",  mcause_m,  64'd11);
    chk("exc_mstatus", mstatus_m, 64'hA_0000_1880);

    // mret with mepc 0x80000014.
    poke(12'h341, 64'h8000_0014);
    request(1'b1, 4'd0, 64'd0);
    tick();
    i_valid = 1'b0;
    chk("mret_c1_waddr", 64'(o_csr_waddr), 64'h300);
    chk("mret_c1_wdata", o_csr_wdata,      64'hA_0000_1888);
    chk("mret_c1_redir", 64'(o_redirect),  64'd0);
    tick();
    chk("mret_c2_redir", 64'(o_redirect),  64'd1);
    chk("mret_c2_pc",    o_nextpc,         64'h8000_0014);
    chk("mret_c2_raddr", 64'(o_csr_raddr), 64'h341);
    tick();
    chk("mret_idle_ready", 64'(o_ready),   64'd1);
    chk("mret_mstatus",    mstatus_m,      64'hA_0000_1888);

    // i_valid held high with a changed epc while busy.
    request(1'b0, 4'd2, 64'h8000_0020);
    tick();
    i_epc  = 64'h8000_0099;
    i_mret = 1'b1;
    chk("hold_wdata", o_csr_wdata, 64'h8000_0020);
    for (int c = 0; c < 4; c++) begin
      chk("hold_ready_low", 64'(o_ready), 64'd0);
      if (c == 3) begin
        chk("hold_pc", o_nextpc, 64'h8000_0100);
        i_valid = 1'b0;
      end
      tick();
    end
    chk("hold_ready_back", 64'(o_ready),   64'd1);
    chk("hold_no_wen",     64'(o_csr_wen), 64'd0);
    chk("hold_mepc",       mepc_m,         64'h8000_0020);
    chk("hold_mcause",     mcause_m,       64'd2);
    chk("hold_mstatus",    mstatus_m,      64'hA_0000_1880);

    // Reset pulsed during the mcause write.
    request(1'b0, 4'd5, 64'h8000_0040);
    tick();
    i_valid = 1'b0;
    tick();
    chk("rstmid_waddr", 64'(o_csr_waddr), 64'h342);
    #1;
    i_rst = 1'b1;
    #1;
    chk("rstmid_ready", 64'(o_ready),   64'd1);
    chk("rstmid_wen",   64'(o_csr_wen), 64'd0);
    tick();
    i_rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("rstmid_quiet", {62'd0, o_csr_wen, o_redirect}, 64'd0);
      tick();
    end
    chk("rstmid_mepc",   mepc_m,   64'h8000_0040);
    chk("rstmid_mcause", mcause_m, 64'd2);

    // Exception, then mret requested right after the redirect.
    request(1'b0, 4'd3, 64'h8000_0050);
    tick();
    i_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("b2b_vec_pc", o_nextpc, 64'h8000_0100);
    request(1'b1, 4'd0, 64'd0);
    tick();
    chk("b2b_idle_ready", 64'(o_ready),    64'd1);
    chk("b2b_idle_redir", 64'(o_redirect), 64'd0);
    tick();
    i_valid = 1'b0;
    chk("b2b_mstat_wdata", o_csr_wdata, 64'hA_0000_1880);
    tick();
    chk("b2b_redir", 64'(o_redirect), 64'd1);
    chk("b2b_pc",    o_nextpc,        64'h8000_0050);
    tick();
    chk("b2b_mstatus", mstatus_m, 64'hA_0000_1880);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
